vending_input_conditioner: RTL and testbench

- Front-end stage that feeds vending_design. It conditions the raw coin-slot sensor and the 2-bit product selector switch.
- Outputs are clean, synchronous signals: a single-cycle `coin` pulse per physical coin, and a debounced, stable `select` code.
- Detects a jammed coin sensor (held high too long), raises `coin_jam` and suppresses further coin pulses until the jam clears.

---
 rtl/vending_pkg.sv | 16 +
 rtl/sync_debounce.sv | 49 ++++
 rtl/vending_input_conditioner.sv | 94 +++++++++
 tb/tb_vending_input_conditioner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and default timing constants for the vending front end and its tests.
package vending_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEFAULT_STUCK_CYCLES    = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL_HI = 3'd1,
    PULSE   = 3'd2,
    HELD    = 3'd3,
    QUAL_LO = 3'd4,
    JAM     = 3'd5
  } coin_state_t;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stable-value debouncer.
// Emits a one-cycle change strobe whenever the debounced value updates.
module sync_debounce #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             change
);

  localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    scnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= '0;
      s2     <= '0;
      cand   <= '0;
      scnt   <= '0;
      dout   <= '0;
      change <= 1'b0;
    end else begin
      s1     <= din;
      s2     <= s1;
      change <= 1'b0;
      if (s2 != cand) begin
        cand <= s2;
        scnt <= '0;
      end else if (scnt == LAST) begin
        // Saturated: only publish when the stable candidate is actually new.
        if (cand != dout) begin
          dout   <= cand;
          change <= 1'b1;
        end
      end else begin
        scnt <= scnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vending_input_conditioner.sv
// Conditions the raw coin sensor (debounce, one pulse per coin, jam detection)
// and the product selector switch for vending_design.
module vending_input_conditioner
  import vending_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEFAULT_STUCK_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_raw,
  input  logic [1:0] select_raw,
  output logic       coin,
  output logic [1:0] select,
  output logic       select_strobe,
  output logic       coin_jam
);

  localparam int unsigned      CNT_W      = $clog2(STUCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);

  logic             coin_s1;
  logic             cs;
  coin_state_t      state;
  coin_state_t      state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  sync_debounce #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_select (
    .clk   (clk),
    .reset (reset),
    .din   (select_raw),
    .dout  (select),
    .change(select_strobe)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coin_s1 <= 1'b0;
      cs      <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
    end else begin
      coin_s1 <= coin_raw;
      cs      <= coin_s1;
      state   <= state_nx;
      cnt     <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (cs) state_nx = QUAL_HI;
      end
      QUAL_HI: begin
        if (!cs)                  state_nx = IDLE;
        else if (cnt == DEB_LAST) state_nx = PULSE;
        else                      cnt_nx   = cnt + 1'b1;
      end
      PULSE: begin
        state_nx = HELD;
      end
      HELD: begin
        if (!cs)                    state_nx = QUAL_LO;
        else if (cnt == STUCK_LAST) state_nx = JAM;
        else                        cnt_nx   = cnt + 1'b1;
      end
      QUAL_LO: begin
        if (cs)                   state_nx = HELD;
        else if (cnt == DEB_LAST) state_nx = IDLE;
        else                      cnt_nx   = cnt + 1'b1;
      end
      JAM: begin
        if (cs)                   cnt_nx   = '0;
        else if (cnt == DEB_LAST) state_nx = IDLE;
        else                      cnt_nx   = cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    // Every state entry restarts the shared counter.
    if (state_nx != state) cnt_nx = '0;
  end

  assign coin     = (state == PULSE);
  assign coin_jam = (state == JAM);

endmodule

// File: tb/tb_vending_input_conditioner.sv
// Self-checking bench: run-length reference model compared every cycle,
// plus table-driven coin/select records and hand-written reset/jam sequences.
module tb_vending_input_conditioner;

  localparam int D = 4;
  localparam int S = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_raw;
  logic [1:0] select_raw;
  logic       coin;
  logic [1:0] select;
  logic       select_strobe;
  logic       coin_jam;

  always #5 clk = ~clk;

  vending_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .STUCK_CYCLES   (S)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_raw     (coin_raw),
    .select_raw   (select_raw),
    .coin         (coin),
    .select       (select),
    .select_strobe(select_strobe),
    .coin_jam     (coin_jam)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state: input delay lines plus run lengths of the seen level
  logic       cq0, cq1;
  logic [1:0] sq0, sq1;
  logic       engaged, jammed, blind;
  int         hi, lo;
  logic       m_coin, m_jam, m_strobe;
  logic [1:0] m_sel, cand;
  int         run;

  int cyc, pulse_cnt, strobe_cnt, first_pulse, first_strobe, first_jam;

  typedef struct {
    int         hi_len;
    logic [1:0] sel;
    int         exp_pulses;
    int         exp_first_pulse;
    int         exp_strobes;
    int         exp_first_jam;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cq0 = 0; cq1 = 0; sq0 = '0; sq1 = '0;
    engaged = 0; jammed = 0; blind = 0; hi = 0; lo = 0;
    m_coin = 0; m_jam = 0; m_strobe = 0; m_sel = '0; cand = '0; run = 1;
  endtask

  task automatic clear_stats();
    cyc = -1; pulse_cnt = 0; strobe_cnt = 0;
    first_pulse = -1; first_strobe = -1; first_jam = -1;
  endtask

  task automatic model_edge(input logic c, input logic [1:0] s);
    logic       v;
    logic [1:0] vs;
    v  = cq1; cq1 = cq0; cq0 = c;
    vs = sq1; sq1 = sq0; sq0 = s;
    m_coin = 0; m_strobe = 0;
    if (jammed) begin
      if (v) lo = 0;
      else begin
        lo++;
        if (lo == D) begin jammed = 0; lo = 0; hi = 0; end
      end
    end else if (blind) begin
      blind = 0; hi = 1; lo = 0;
    end else if (engaged) begin
      if (v) begin
        hi++; lo = 0;
        if (hi == S + 1) begin jammed = 1; engaged = 0; end
      end else begin
        lo++; hi = 0;
        if (lo == D + 1) begin engaged = 0; lo = 0; end
      end
    end else begin
      if (v) begin
        hi++;
        if (hi == D + 1) begin m_coin = 1; engaged = 1; blind = 1; hi = 0; end
      end else hi = 0;
    end
    m_jam = jammed;
    if (vs != cand) begin
      cand = vs; run = 1;
    end else if (run < D + 1) run++;
    if (run == D + 1 && cand != m_sel) begin
      m_sel = cand; m_strobe = 1;
    end
  endtask

  task automatic tick(input logic c, input logic [1:0] s);
    coin_raw   = c;
    select_raw = s;
    @(posedge clk);
    model_edge(c, s);
    cyc++;
    #1;
    check("coin", coin, m_coin);
    check("coin_jam", coin_jam, m_jam);
    check("select", select, m_sel);
    check("select_strobe", select_strobe, m_strobe);
    if (coin === 1'b1) begin
      pulse_cnt++;
      if (first_pulse < 0) first_pulse = cyc;
    end
    if (select_strobe === 1'b1) begin
      strobe_cnt++;
      if (first_strobe < 0) first_strobe = cyc;
    end
    if (coin_jam === 1'b1 && first_jam < 0) first_jam = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coin"}, coin, 0);
    check({tag, "_select"}, select, 0);
    check({tag, "_strobe"}, select_strobe, 0);
    check({tag, "_jam"}, coin_jam, 0);
  endtask

  // assert reset between edges, check outputs immediately, release before next edge
  task automatic async_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_outputs(tag);
    #1;
    reset = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{20,  2'b10, 1,  6,  1, -1};
    vecs[1] = '{3,   2'b10, 0, -1,  0, -1};
    vecs[2] = '{4,   2'b01, 0, -1,  1, -1};
    vecs[3] = '{5,   2'b01, 1,  6,  0, -1};
    vecs[4] = '{100, 2'b11, 1,  6,  1, D + 2 + 1 + S};
    vecs[5] = '{20,  2'b11, 1,  6,  0, -1};

    model_reset();
    clear_stats();

    // reset held with inputs active
    reset = 1'b0; coin_raw = 1'b1; select_raw = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    #3;
    reset = 1'b1;
    clear_stats();
    repeat (12) tick(1'b1, 2'b11);
    check("release_first_pulse", first_pulse, D + 2);
    check("release_first_strobe", first_strobe, D + 2);
    check("release_pulse_count", pulse_cnt, 1);
    repeat (20) tick(1'b0, 2'b11);

    // table-driven coin lengths with concurrent select changes
    for (int i = 0; i < 6; i++) begin
      clear_stats();
      for (int j = 0; j < vecs[i].hi_len; j++) tick(1'b1, vecs[i].sel);
      repeat (30) tick(1'b0, vecs[i].sel);
      check($sformatf("vec%0d_pulses", i), pulse_cnt, vecs[i].exp_pulses);
      check($sformatf("vec%0d_first_pulse", i), first_pulse, vecs[i].exp_first_pulse);
      check($sformatf("vec%0d_strobes", i), strobe_cnt, vecs[i].exp_strobes);
      check($sformatf("vec%0d_select", i), select, vecs[i].sel);
      check($sformatf("vec%0d_first_jam", i), first_jam, vecs[i].exp_first_jam);
    end

    // release bounce inside a held coin
    clear_stats();
    repeat (8) tick(1'b1, 2'b11);
    repeat (2) tick(1'b0, 2'b11);
    repeat (10) tick(1'b1, 2'b11);
    repeat (20) tick(1'b0, 2'b11);
    check("dip_pulses", pulse_cnt, 1);

    // selector bounce 00 -> 10
    repeat (10) tick(1'b0, 2'b00);
    clear_stats();
    tick(1'b0, 2'b10);
    tick(1'b0, 2'b00);
    tick(1'b0, 2'b10);
    repeat (12) tick(1'b0, 2'b10);
    check("bounce_strobes", strobe_cnt, 1);
    check("bounce_select", select, 2'b10);
    clear_stats();
    repeat (10) tick(1'b0, 2'b10);
    check("same_value_strobes", strobe_cnt, 0);

    // reset during HELD, then during JAM
    clear_stats();
    repeat (12) tick(1'b1, 2'b01);
    check("held_pulses", pulse_cnt, 1);
    check("held_pulse_with_strobe", first_strobe, first_pulse);
    async_reset("held_reset");
    clear_stats();
    repeat (80) tick(1'b1, 2'b01);
    check("after_held_first_pulse", first_pulse, D + 2);
    check("jam_before_reset", coin_jam, 1);
    async_reset("jam_reset");
    clear_stats();
    repeat (10) tick(1'b1, 2'b01);
    check("after_jam_first_pulse", first_pulse, D + 2);
    check("after_jam_pulses", pulse_cnt, 1);
    repeat (20) tick(1'b0, 2'b01);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic c;
      logic [1:0] s;
      c = ($urandom_range(0, 7) < 5) ? coin_raw : ~coin_raw;
      s = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : select_raw;
      if ($urandom_range(0, 199) == 0) repeat (S + 10) tick(1'b1, s);
      tick(c, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
